// File: rtl/sram22_march_bist.sv
// March C- BIST for one sram22 macro: one SRAM op per cycle, 10241 busy cycles for a passing run.
// The start pulse is ignored while busy. The first mismatch is captured and ends the test.
module sram22_march_bist #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [2:0]             fail_elem,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   pat_q, pat_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic [2:0]              cmp_elem_q, cmp_elem_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_exp_d;
  logic                    fail_q, fail_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;

  logic                    running, is_read, is_write, down, last_addr, last_op;
  logic                    mismatch;
  logic [DATA_WIDTH-1:0]   rd_exp, wr_data;

  // E0/E5 are single-op elements; E1..E4 read on phase 0 and write on phase 1.
  always_comb begin
    running   = (state_q == S_RUN);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
    last_addr = down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    is_read   = running && ((elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q));
    is_write  = running && ((elem_q == 3'd0) || ((elem_q != 3'd5) && phase_q));
    rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pat_q : pat_q;
    wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~pat_q : pat_q;
    mismatch  = cmp_valid_q && !fail_q && ((state_q == S_RUN) || (state_q == S_FLUSH))
                && (sram_dout != cmp_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    pat_d       = pat_q;
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    cmp_valid_d = is_read;
    cmp_elem_d  = elem_q;
    cmp_addr_d  = addr_q;
    cmp_exp_d   = rd_exp;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          phase_d     = 1'b0;
          pat_d       = pattern;
          fail_d      = 1'b0;
          fail_elem_d = 3'd0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      S_RUN: begin
        if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_addr) begin
            if (elem_q == 3'd5) begin
              state_d = S_FLUSH;
            end else begin
              elem_d = elem_q + 3'd1;
              // E3 and E4 sweep downwards from the top address.
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
            end
          end else begin
            addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      state_d     = S_DONE;
      fail_d      = 1'b1;
      fail_elem_d = cmp_elem_q;
      fail_addr_d = cmp_addr_q;
      fail_data_d = sram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      pat_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_elem_q  <= 3'd0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      fail_q      <= 1'b0;
      fail_elem_q <= 3'd0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      pat_q       <= pat_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_elem_q  <= cmp_elem_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign fail       = fail_q;
  assign fail_elem  = fail_elem_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign sram_we    = is_write;
  assign sram_wmask = {WMASK_WIDTH{is_write}};
  assign sram_addr  = running ? addr_q : '0;
  assign sram_din   = is_write ? wr_data : '0;

endmodule
